uart_pkt_parser: RTL and testbench
==================================

Name: uart_pkt_parser

Overview:
- Sits directly downstream of the UART receiver FSM. Consumes its 8-bit byte and one-cycle ready strobe.
- Assembles bytes into framed command packets: SYNC, LEN, payload, checksum.
- Presents validated payloads to game/control logic as a registered wide word with a one-cycle valid pulse. Malformed or stalled frames raise a one-cycle error pulse with a code.

Parameters:
- MAX_PAYLOAD, 8: maximum payload bytes per frame; legal LEN is 1..MAX_PAYLOAD.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CLKS, 325_000: idle clocks allowed between bytes inside a frame (5 ms at 65 MHz).

Ports:
- clk_in  input  1  system clock (65 MHz).
- rst_n_in  input  1  asynchronous, active-low reset.
- byte_in  input  8  received byte from the UART receiver.
- byte_valid_in  input  1  one-cycle strobe; byte_in is valid this cycle.
- cmd_out  output  MAX_PAYLOAD*8  last good payload; byte 0 in bits [7:0]; unused bytes zero.
- len_out  output  $clog2(MAX_PAYLOAD+1)  payload length of cmd_out.
- pkt_valid_out  output  1  one-cycle pulse; cmd_out/len_out just updated.
- pkt_err_out  output  1  one-cycle pulse; frame aborted.
- err_code_out  output  2  1 = bad LEN, 2 = checksum mismatch, 3 = timeout; holds its value until the next error.

Behaviour:
- Reset: the interface is one clock; reset is asynchronous and active-low. On reset, every output, the shadow buffer, the counters and the checksum go to 0, and the state goes to IDLE.
- FSM states and transitions:
  - IDLE: byte_valid_in with byte_in==SYNC_BYTE -> LEN. Any other byte is silently dropped.
  - LEN: on byte_valid_in, 1<=byte<=MAX_PAYLOAD -> PAYLOAD. Store len, set checksum=byte, set idx=0, clear shadow buffer. Otherwise -> IDLE with error 1.
  - PAYLOAD: on byte_valid_in, write shadow[idx], add the byte to the checksum, idx++. When idx==len-1 on accept -> CHECK.
  - CHECK: on byte_valid_in, byte==checksum -> IDLE. Copy shadow to cmd_out, len to len_out, pulse pkt_valid_out. Otherwise -> IDLE with error 2.
- Checksum: 8-bit sum mod 256 of the LEN byte and all payload bytes. Wrap is intended.
- Latency: pkt_valid_out/pkt_err_out rise in the cycle after the deciding byte_valid_in. cmd_out changes in that same cycle.
- cmd_out/len_out change only on a good packet. Errors leave them untouched.
- Timeout:
  - The gap counter clears on every byte_valid_in and is held at 0 in IDLE.
  - It increments in LEN/PAYLOAD/CHECK.
  - Reaching TIMEOUT_CLKS-1 -> IDLE with error 3.
  - Simultaneous byte_valid_in and terminal count: the byte wins, the counter clears, and no error is raised.
- A SYNC_BYTE value inside LEN/PAYLOAD/CHECK is data, not a restart.
- After any error the parser is in IDLE and accepts a SYNC on the very next byte_valid_in.
- Asynchronous reset mid-frame discards the partial frame. No pulse is emitted.
- byte_valid_in held high for multiple cycles counts as multiple bytes. The upstream block guarantees single-cycle strobes.

Optional Feature:
- UART_PKT_STATS_EN defined:
  - Adds output ports good_cnt_out[15:0] and err_cnt_out[15:0].
  - good_cnt_out increments on each pkt_valid_out; err_cnt_out increments on each pkt_err_out.
  - Both saturate at 16'hFFFF and clear only on reset.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package uart_pkt_pkg:
  - parser state enum (IDLE, LEN, PAYLOAD, CHECK);
  - err_code typedef and constants ERR_NONE=0, ERR_LEN=1, ERR_CSUM=2, ERR_TIMEOUT=3;
  - default SYNC_BYTE.
- One sub-module is natural: uart_gap_timer (parameter TIMEOUT_CLKS; inputs clear, enable; output expired pulse).

Test Plan:
- Good frame A5,03,11,22,33,69 at UART spacing -> pkt_valid_out one cycle after byte 69; cmd_out low 24 bits = 33_22_11, upper bits 0; len_out=3; no error.
- Bad checksum A5,02,10,20,00 -> pkt_err_out pulse with err_code_out=2; cmd_out unchanged from the previous good frame.
- Bad length A5,00 and A5,09 (MAX_PAYLOAD=8) -> err_code_out=1 after the LEN byte; a following good frame A5,01,7F,80 is accepted.
- Stall: A5,02,10, then no bytes for TIMEOUT_CLKS clocks -> err_code_out=3 at count TIMEOUT_CLKS-1. A byte arriving exactly at terminal count -> no error, frame continues.
- Wrap and sync-as-data: A5,02,A5,FF,A6 -> valid; cmd_out[15:0]=FF_A5; checksum wrap verified.
- Assert rst_n_in low mid-payload with no clock edge -> outputs 0 immediately; after release, a good frame parses. With UART_PKT_STATS_EN, the counters read 0 then 1.

Source files
------------

// File: rtl/uart_pkt_parser_pkg.sv
// Shared types and constants for the UART packet parser.
// Parser states: IDLE (hunt for SYNC), LEN (expect length byte),
// PAYLOAD (collect data bytes), CHECK (expect checksum byte).
package uart_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } parser_state_e;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'd0;
  localparam err_code_t ERR_LEN     = 2'd1;
  localparam err_code_t ERR_CSUM    = 2'd2;
  localparam err_code_t ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Running checksum: plain 8-bit add, wrap-around is part of the protocol.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_pkt_parser_if.sv
// Byte-in / packet-out bundle between the UART receiver side and the parser.
// master: the block feeding bytes and consuming packets; slave: the parser.
interface uart_pkt_parser_if #(
  parameter int MAX_PAYLOAD = 8
) ();
  import uart_pkt_pkg::*;

  localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);

  logic [7:0]               byte_in;
  logic                     byte_valid_in;
  logic [MAX_PAYLOAD*8-1:0] cmd_out;
  logic [LEN_W-1:0]         len_out;
  logic                     pkt_valid_out;
  logic                     pkt_err_out;
  err_code_t                err_code_out;

  modport master (
    output byte_in, byte_valid_in,
    input  cmd_out, len_out, pkt_valid_out, pkt_err_out, err_code_out
  );

  modport slave (
    input  byte_in, byte_valid_in,
    output cmd_out, len_out, pkt_valid_out, pkt_err_out, err_code_out
  );

endinterface

// File: rtl/uart_pkt_parser_gap.sv
// Inter-byte gap timer: counts idle clocks while enabled, restarts on clear,
// and flags expiry in the cycle the count sits at TIMEOUT_CLKS-1 with no clear.
module uart_gap_timer #(
  parameter int TIMEOUT_CLKS = 325_000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_tc;

  assign at_tc     = (cnt_q == TC);
  assign expired_o = enable_i && !clear_i && at_tc;

  // A byte always beats the terminal count; the parser leaves the frame on expiry.
  always_comb begin
    cnt_d = cnt_q + ONE;
    if (clear_i || !enable_i || at_tc) begin
      cnt_d = '0;
    end
  end

  // Gap count register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_pkt_parser.sv
// Frame parser: SYNC, LEN, payload, checksum -> registered command word.
// Optional statistics counters are built when UART_PKT_STATS_EN is defined.
module uart_pkt_parser
  import uart_pkt_pkg::*;
#(
  parameter int         MAX_PAYLOAD  = 8,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CLKS = 325_000
) (
  input logic clk_in,
  input logic rst_n_in,
  uart_pkt_parser_if.slave bus
`ifdef UART_PKT_STATS_EN
  ,
  output logic [15:0] good_cnt_out,
  output logic [15:0] err_cnt_out
`endif
);

  localparam int               LEN_W     = $clog2(MAX_PAYLOAD + 1);
  localparam int               CMD_W     = MAX_PAYLOAD * 8;
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_PAYLOAD);
  localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

  parser_state_e    state_q, state_d;
  logic [LEN_W-1:0] plen_q, plen_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [7:0]       csum_q, csum_d;
  logic [CMD_W-1:0] shadow_q, shadow_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  err_code_t        code_q, code_d;
  logic             expired;

  uart_gap_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_gap (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .clear_i   (bus.byte_valid_in),
    .enable_i  (state_q != IDLE),
    .expired_o (expired)
  );

  // Next state, frame datapath and output pulses.
  always_comb begin
    state_d  = state_q;
    plen_d   = plen_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    shadow_d = shadow_q;
    cmd_d    = cmd_q;
    len_d    = len_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    unique case (state_q)
      IDLE: begin
        if (bus.byte_valid_in && bus.byte_in == SYNC_BYTE) begin
          state_d = LEN;
        end
      end
      LEN: begin
        if (bus.byte_valid_in) begin
          if (bus.byte_in != 8'd0 && bus.byte_in <= MAX_LEN_B) begin
            state_d  = PAYLOAD;
            plen_d   = bus.byte_in[LEN_W-1:0];
            csum_d   = bus.byte_in;
            idx_d    = '0;
            shadow_d = '0;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
            code_d  = ERR_LEN;
          end
        end else if (expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end
      PAYLOAD: begin
        if (bus.byte_valid_in) begin
          for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (idx_q == LEN_W'(i)) begin
              shadow_d[i*8 +: 8] = bus.byte_in;
            end
          end
          csum_d = csum_add(csum_q, bus.byte_in);
          idx_d  = idx_q + ONE_L;
          if (idx_q == plen_q - ONE_L) begin
            state_d = CHECK;
          end
        end else if (expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end
      CHECK: begin
        if (bus.byte_valid_in) begin
          state_d = IDLE;
          if (bus.byte_in == csum_q) begin
            cmd_d   = shadow_q;
            len_d   = plen_q;
            valid_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CSUM;
          end
        end else if (expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      plen_q   <= '0;
      idx_q    <= '0;
      csum_q   <= '0;
      shadow_q <= '0;
      cmd_q    <= '0;
      len_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      plen_q   <= plen_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      shadow_q <= shadow_d;
      cmd_q    <= cmd_d;
      len_q    <= len_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign bus.cmd_out       = cmd_q;
  assign bus.len_out       = len_q;
  assign bus.pkt_valid_out = valid_q;
  assign bus.pkt_err_out   = err_q;
  assign bus.err_code_out  = code_q;

`ifdef UART_PKT_STATS_EN
  logic [15:0] good_q, good_d;
  logic [15:0] bad_q, bad_d;

  // Saturating counters step together with the pulse they count.
  always_comb begin
    good_d = good_q;
    bad_d  = bad_q;
    if (valid_d && good_q != 16'hFFFF) good_d = good_q + 16'd1;
    if (err_d && bad_q != 16'hFFFF)    bad_d  = bad_q + 16'd1;
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

  assign good_cnt_out = good_q;
  assign err_cnt_out  = bad_q;
`endif

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Bench for uart_pkt_parser: fixed vector table, timeout/reset sequences,
// and random frames checked against a frame-level model.
module tb_uart_pkt_parser;
  import uart_pkt_pkg::*;

  localparam int MAXP = 8;
  localparam int TO   = 20;
  localparam int LW   = $clog2(MAXP + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_pkt_parser_if #(.MAX_PAYLOAD(MAXP)) bus ();

`ifdef UART_PKT_STATS_EN
  logic [15:0] good_cnt, err_cnt;
`endif

  uart_pkt_parser #(
    .MAX_PAYLOAD (MAXP),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus.slave)
`ifdef UART_PKT_STATS_EN
    ,
    .good_cnt_out(good_cnt),
    .err_cnt_out (err_cnt)
`endif
  );

  typedef struct {
    logic [7:0]  b[12];
    int          n;
    bit          ev;
    bit          ee;
    logic [1:0]  code;
    logic [63:0] cmd;
    logic [LW-1:0] len;
  } vec_t;

  vec_t tbl[8];

  int total = 0;
  int bad = 0;
  int mon_valid = 0, mon_err = 0;
  int exp_valid_n = 0, exp_err_n = 0;
  int exp_good_st = 0, exp_err_st = 0;
  logic [63:0]   exp_cmd = '0;
  logic [LW-1:0] exp_len = '0;
  logic [1:0]    exp_code = '0;

  always @(negedge clk) begin
    if (bus.pkt_valid_out) mon_valid++;
    if (bus.pkt_err_out) mon_err++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.byte_in = b;
    bus.byte_valid_in = 1'b1;
    @(negedge clk);
    bus.byte_valid_in = 1'b0;
  endtask

  // Frame-level reference: decides outcome from LEN range and mod-256 sum.
  task automatic model_frame(input logic [7:0] fr[$], output bit v, output bit e);
    int n, s;
    v = 0;
    e = 0;
    n = int'(fr[1]);
    if (n < 1 || n > MAXP) begin
      e = 1;
      exp_code = 2'd1;
      return;
    end
    s = n;
    for (int i = 0; i < n; i++) s += int'(fr[2 + i]);
    if ((s % 256) == int'(fr[2 + n])) begin
      v = 1;
      exp_cmd = '0;
      for (int i = 0; i < n; i++) exp_cmd[i*8 +: 8] = fr[2 + i];
      exp_len = LW'(n);
    end else begin
      e = 1;
      exp_code = 2'd2;
    end
  endtask

  task automatic run_frame(input string nm, input logic [7:0] fr[$], input bit ev,
                           input bit ee, input int maxgap);
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i]);
      if (i != fr.size() - 1) repeat ($urandom_range(0, maxgap)) @(negedge clk);
    end
    check({nm, " valid"}, 64'(bus.pkt_valid_out), 64'(ev));
    check({nm, " err"}, 64'(bus.pkt_err_out), 64'(ee));
    check({nm, " code"}, 64'(bus.err_code_out), 64'(exp_code));
    check({nm, " cmd"}, bus.cmd_out, exp_cmd);
    check({nm, " len"}, 64'(bus.len_out), 64'(exp_len));
    @(negedge clk);
    check({nm, " pulse drop"}, 64'(bus.pkt_valid_out | bus.pkt_err_out), 64'd0);
    exp_valid_n += int'(ev);
    exp_err_n   += int'(ee);
    exp_good_st += int'(ev);
    exp_err_st  += int'(ee);
  endtask

  task automatic check_stats(input string nm);
`ifdef UART_PKT_STATS_EN
    check({nm, " good_cnt"}, 64'(good_cnt), 64'(exp_good_st));
    check({nm, " err_cnt"}, 64'(err_cnt), 64'(exp_err_st));
`else
    check({nm, " no stats"}, 64'(mon_valid + mon_err), 64'(exp_valid_n + exp_err_n));
`endif
  endtask

  initial begin
    logic [7:0] fr[$];
    bit v, e;
    int n, kind;
    logic [7:0] s;

    tbl[0] = '{b: '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69, 0, 0, 0, 0, 0, 0}, n: 6,
               ev: 1, ee: 0, code: 0, cmd: 64'h332211, len: 3};
    tbl[1] = '{b: '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00, 0, 0, 0, 0, 0, 0, 0}, n: 5,
               ev: 0, ee: 1, code: 2, cmd: 64'h332211, len: 3};
    tbl[2] = '{b: '{8'hA5, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, n: 2,
               ev: 0, ee: 1, code: 1, cmd: 64'h332211, len: 3};
    tbl[3] = '{b: '{8'hA5, 8'h09, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, n: 2,
               ev: 0, ee: 1, code: 1, cmd: 64'h332211, len: 3};
    tbl[4] = '{b: '{8'hA5, 8'h01, 8'h7F, 8'h80, 0, 0, 0, 0, 0, 0, 0, 0}, n: 4,
               ev: 1, ee: 0, code: 1, cmd: 64'h7F, len: 1};
    tbl[5] = '{b: '{8'hA5, 8'h02, 8'hA5, 8'hFF, 8'hA6, 0, 0, 0, 0, 0, 0, 0}, n: 5,
               ev: 1, ee: 0, code: 1, cmd: 64'hFFA5, len: 2};
    tbl[6] = '{b: '{8'hA5, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h2C, 0},
               n: 11, ev: 1, ee: 0, code: 1, cmd: 64'h0807060504030201, len: 8};
    tbl[7] = '{b: '{8'h00, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h01, 0, 0, 0, 0, 0, 0}, n: 6,
               ev: 1, ee: 0, code: 1, cmd: 64'h0, len: 1};

    bus.byte_in = '0;
    bus.byte_valid_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset cmd", bus.cmd_out, 64'd0);
    check("reset len", 64'(bus.len_out), 64'd0);
    check("reset code", 64'(bus.err_code_out), 64'd0);
    check("reset pulses", 64'(bus.pkt_valid_out | bus.pkt_err_out), 64'd0);
    rst_n = 1'b1;
    check_stats("reset");

    for (int t = 0; t < 8; t++) begin
      fr = {};
      for (int i = 0; i < tbl[t].n; i++) fr.push_back(tbl[t].b[i]);
      exp_cmd  = tbl[t].cmd;
      exp_len  = tbl[t].len;
      exp_code = tbl[t].code;
      run_frame($sformatf("vec%0d", t), fr, tbl[t].ev, tbl[t].ee, 3);
    end
    check_stats("table");

    // Stall after the first payload byte.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
    repeat (TO - 1) @(negedge clk);
    check("timeout early", 64'(bus.pkt_err_out), 64'd0);
    @(negedge clk);
    check("timeout err", 64'(bus.pkt_err_out), 64'd1);
    check("timeout code", 64'(bus.err_code_out), 64'd3);
    check("timeout cmd kept", bus.cmd_out, exp_cmd);
    exp_code = 2'd3;
    exp_err_n++;
    exp_err_st++;
    @(negedge clk);
    fr = {8'hA5, 8'h01, 8'h7F, 8'h80};
    exp_cmd = 64'h7F; exp_len = 1;
    run_frame("after timeout", fr, 1, 0, 0);

    // Byte lands exactly on the terminal count.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
    repeat (TO - 2) @(negedge clk);
    send_byte(8'h20);
    check("tc byte no err", 64'(bus.pkt_err_out), 64'd0);
    repeat (TO - 2) @(negedge clk);
    fr = {8'h32};
    exp_cmd = 64'h2010; exp_len = 2;
    run_frame("tc frame", fr, 1, 0, 0);
    check_stats("seq");

    // Random frames against the model.
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(0, 2)) begin
        s = 8'($urandom_range(0, 255));
        if (s == 8'hA5) s = 8'h5A;
        send_byte(s);
      end
      kind = $urandom_range(0, 5);
      fr = {8'hA5};
      if (kind == 0) begin
        fr.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(9, 255)));
      end else begin
        n = $urandom_range(1, MAXP);
        fr.push_back(8'(n));
        s = 8'(n);
        for (int i = 0; i < n; i++) begin
          fr.push_back(($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom_range(0, 255)));
          s = s + fr[fr.size() - 1];
        end
        if (kind == 1) s = s ^ 8'($urandom_range(1, 255));
        fr.push_back(s);
      end
      model_frame(fr, v, e);
      run_frame($sformatf("rand%0d", r), fr, v, e, (r % 5 == 0) ? TO - 2 : 4);
    end
    check_stats("random");

    // Asynchronous reset in the middle of a payload.
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst cmd", bus.cmd_out, 64'd0);
    check("arst len", 64'(bus.len_out), 64'd0);
    check("arst code", 64'(bus.err_code_out), 64'd0);
    check("arst pulses", 64'(bus.pkt_valid_out | bus.pkt_err_out), 64'd0);
    exp_cmd = '0; exp_len = '0; exp_code = '0;
    exp_good_st = 0; exp_err_st = 0;
    check_stats("arst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fr = {8'hA5, 8'h01, 8'h7F, 8'h80};
    exp_cmd = 64'h7F; exp_len = 1;
    run_frame("post reset", fr, 1, 0, 2);
    check_stats("post reset");

    repeat (2) @(negedge clk);
    check("valid pulse count", 64'(mon_valid), 64'(exp_valid_n));
    check("err pulse count", 64'(mon_err), 64'(exp_err_n));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
